// File: rtl/md_unit.sv
// md_unit: multi-cycle multiply/divide unit with HI/LO registers.
// Define MD_UNIT_MADD_EN to enable madd (op 7); otherwise op 7 is a no-op.
module md_unit (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [2:0]  md_op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        rd_hi,
  output logic        busy,
  output logic [31:0] MDout
);
  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;
`ifdef MD_UNIT_MADD_EN
  localparam logic [2:0] OP_MADD  = 3'd7;
`endif
  logic [31:0] r_hi, r_lo, r_a, r_b;
  logic [3:0]  r_cnt;
  logic [2:0]  r_op;
  logic        w_acc, w_mul, w_div, w_wr;
  logic [31:0] w_ua, w_ub, w_q, w_r;
  logic [63:0] w_res;
  assign busy  = r_cnt != 4'd0;
  assign MDout = rd_hi ? r_hi : r_lo;
  assign w_acc = start && !busy;
`ifdef MD_UNIT_MADD_EN
  assign w_mul = md_op == OP_MULT || md_op == OP_MULTU || md_op == OP_MADD;
`else
  assign w_mul = md_op == OP_MULT || md_op == OP_MULTU;
`endif
  assign w_div = md_op == OP_DIV || md_op == OP_DIVU;
  // Signed divide works on magnitudes; INT_MIN / -1 falls out as 0x80000000 rem 0.
  always_comb begin
    w_ua  = (r_op == OP_DIV && r_a[31]) ? -r_a : r_a;
    w_ub  = (r_op == OP_DIV && r_b[31]) ? -r_b : r_b;
    w_q   = w_ua / w_ub;
    w_r   = w_ua % w_ub;
    w_res = {r_hi, r_lo};
    w_wr  = !((r_op == OP_DIV || r_op == OP_DIVU) && r_b == 32'd0);
    case (r_op)
      OP_MULT:  w_res = 64'($signed(r_a)) * 64'($signed(r_b));
      OP_MULTU: w_res = 64'(r_a) * 64'(r_b);
      OP_DIV:   w_res = {r_a[31] ? -w_r : w_r, (r_a[31] ^ r_b[31]) ? -w_q : w_q};
      OP_DIVU:  w_res = {w_r, w_q};
`ifdef MD_UNIT_MADD_EN
      OP_MADD:  w_res = {r_hi, r_lo} + 64'($signed(r_a)) * 64'($signed(r_b));
`endif
      default:  w_res = {r_hi, r_lo};
    endcase
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_hi  <= '0;
      r_lo  <= '0;
      r_a   <= '0;
      r_b   <= '0;
      r_op  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_acc && (w_mul || w_div)) begin
        r_a   <= A;
        r_b   <= B;
        r_op  <= md_op;
        r_cnt <= w_div ? 4'd10 : 4'd5;
      end else if (busy) r_cnt <= r_cnt - 4'd1;
      if (r_cnt == 4'd1 && w_wr) begin
        r_hi <= w_res[63:32];
        r_lo <= w_res[31:0];
      end
      if (w_acc && md_op == OP_MTHI) r_hi <= A;
      if (w_acc && md_op == OP_MTLO) r_lo <= A;
    end
  end
endmodule

// File: tb/tb_md_unit.sv
// tb_md_unit: randomized scoreboard bench for md_unit against an arithmetic HI/LO model.
module tb_md_unit;
  logic        clk = 0, reset_n = 0, start = 0, rd_hi = 0, busy, probe = 0, prev_busy = 0;
  logic [2:0]  md_op = 0;
  logic [31:0] A = 0, B = 0, MDout, m_hi = 0, m_lo = 0;
  int          total = 0, bad = 0;
  typedef struct {logic [31:0] hi; logic [31:0] lo; int lat;} item_t;
  item_t sb[$];

  md_unit dut (.clk(clk), .reset_n(reset_n), .start(start), .md_op(md_op), .A(A), .B(B),
               .rd_hi(rd_hi), .busy(busy), .MDout(MDout));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic int model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sd, p;
    logic [63:0] u;
    int lat;
    lat = 0;
    case (op)
      3'd1: begin p = longint'($signed(a)) * longint'($signed(b)); {m_hi, m_lo} = p; lat = 5; end
      3'd2: begin u = 64'(a) * 64'(b); {m_hi, m_lo} = u; lat = 5; end
      3'd3: begin
        if (b != 0) begin
          sa = longint'($signed(a)); sd = longint'($signed(b));
          m_lo = 32'(sa / sd); m_hi = 32'(sa % sd);
        end
        lat = 10;
      end
      3'd4: begin if (b != 0) begin m_lo = a / b; m_hi = a % b; end lat = 10; end
      3'd5: m_hi = a;
      3'd6: m_lo = a;
`ifdef MD_UNIT_MADD_EN
      3'd7: begin
        p = longint'($signed(a)) * longint'($signed(b));
        {m_hi, m_lo} = {m_hi, m_lo} + 64'(p);
        lat = 5;
      end
`endif
      default: lat = 0;
    endcase
    return lat;
  endfunction

  task automatic push_exp(input int lat);
    item_t it;
    it.hi = m_hi; it.lo = m_lo; it.lat = lat;
    sb.push_back(it);
  endtask

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    int lat;
    lat = model(op, a, b);
    push_exp(lat);
    @(posedge clk); #2 start = 1; md_op = op; A = a; B = b;
    @(posedge clk); #2 start = 0; md_op = 3'($urandom); A = $urandom; B = $urandom;
    if (lat == 0) begin
      probe = 1;
      @(posedge clk); #2 probe = 0;
    end else repeat (lat + 2) @(posedge clk);
  endtask

  // Monitor: a result is presented when busy falls or when the stimulus requests a probe.
  initial begin
    int bcnt;
    logic b_s, p_s;
    logic [31:0] hi, lo;
    item_t it;
    bcnt = 0;
    forever begin
      @(negedge clk);
      b_s = busy; p_s = probe;
      if (b_s) bcnt++;
      else if (prev_busy || p_s) begin
        rd_hi = 1; #1 hi = MDout;
        rd_hi = 0; #1 lo = MDout;
        if (sb.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_result: got hi=%h lo=%h expected no output", hi, lo);
        end else begin
          it = sb.pop_front();
          chk("busy_cycles", 32'(bcnt), 32'(it.lat));
          chk("HI", hi, it.hi);
          chk("LO", lo, it.lo);
        end
        bcnt = 0;
      end
      prev_busy = b_s;
    end
  end

  initial begin
    logic [31:0] a, b;
    logic [2:0] op;
    push_exp(0);
    #2 probe = 1;
    @(negedge clk); #3 probe = 0;
    @(posedge clk); #1 reset_n = 1;
    issue(3'd1, 32'd3, 32'hFFFFFFFE);
    issue(3'd4, 32'd7, 32'd2);
    issue(3'd3, 32'hFFFFFFF9, 32'd2);
    issue(3'd5, 32'h12345678, 32'd9);
    // mult followed by a div start that arrives while busy and must be dropped
    push_exp(model(3'd1, 32'h00010003, 32'hFFFF0007));
    @(posedge clk); #2 start = 1; md_op = 3'd1; A = 32'h00010003; B = 32'hFFFF0007;
    @(posedge clk); #2 start = 0;
    @(posedge clk); #2 start = 1; md_op = 3'd3; A = 32'd100; B = 32'd7;
    @(posedge clk); #2 start = 0; md_op = 3'd0;
    repeat (6) @(posedge clk);
    issue(3'd5, 32'hAA, 32'd0);
    issue(3'd6, 32'hBB, 32'd0);
    issue(3'd3, 32'd5, 32'd0);
    issue(3'd4, 32'h1234, 32'd0);
    issue(3'd3, 32'h80000000, 32'hFFFFFFFF);
    issue(3'd0, 32'hDEADBEEF, 32'd3);
    issue(3'd5, 32'd0, 32'd0);
    issue(3'd6, 32'd4, 32'd0);
    issue(3'd7, 32'd2, 32'd3);
    // reset during busy cycle 3 of a mult: abort, no later write
    m_hi = 0; m_lo = 0; push_exp(3);
    @(posedge clk); #2 start = 1; md_op = 3'd1; A = 32'd3; B = 32'hFFFFFFFE;
    @(posedge clk); #2 start = 0;
    repeat (3) @(negedge clk);
    #3 reset_n = 0;
    #1 chk("busy_async_reset", 32'(busy), 32'd0);
    repeat (2) @(posedge clk);
    m_hi = 32'h5A5A0001; push_exp(0);
    #1 reset_n = 1; start = 1; md_op = 3'd5; A = 32'h5A5A0001;
    @(posedge clk); #2 start = 0; probe = 1;
    @(posedge clk); #2 probe = 0;
    repeat (8) @(posedge clk);
    issue(3'd0, 32'd0, 32'd0);
    repeat (40) begin
      op = 3'($urandom_range(0, 7));
      a = ($urandom_range(0, 4) == 0) ? 32'h80000000 : $urandom;
      b = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) - 32'd1 : $urandom;
      issue(op, a, b);
    end
    repeat (5) @(posedge clk);
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    chk("busy_idle_end", 32'(busy), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
